// File: rtl/i2c_pkg.sv
// Shared types for the paddle-controller I2C target: FSM states and register indices.
package i2c_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StWrData,
      StWrAck,
      StRdData,
      StRdAck
   } i2c_state_e;

   localparam logic [1:0] REG_PADDLE  = 2'd0;
   localparam logic [1:0] REG_BUTTONS = 2'd1;
   localparam logic [1:0] REG_ID      = 2'd2;
   localparam logic [1:0] REG_SCRATCH = 2'd3;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one I2C pad, with edge pulses
// that coincide with the cycle the filtered level changes.
module i2c_line_filter #(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync  <= 2'b11;
         level <= 1'b1;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[0], line_in};
         rise <= 1'b0;
         fall <= 1'b0;
         // cnt counts consecutive synchronised samples that disagree with the accepted level
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sync[1];
            cnt   <= '0;
            rise  <= sync[1];
            fall  <= ~sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_paddle_target.sv
// I2C target serving paddle position, buttons, an ID byte and a scratch register.
// SDA is open-drain (sda_oe=1 pulls low); SCL is never driven.
module i2c_paddle_target #(
   parameter logic [6:0]  ADDR       = 7'h52,
   parameter int unsigned FILTER_LEN = 3,
   parameter logic [7:0]  ID_VALUE   = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [7:0] paddle_y,
   input  logic [3:0] buttons,
   output logic [7:0] scratch,
   output logic       wr_strobe,
   output logic       busy
);
   import i2c_pkg::*;

   logic       scl_f, scl_rise, scl_fall;
   logic       sda_f, sda_rise, sda_fall;
   i2c_state_e state;
   logic [7:0] shreg, tx_byte, rd_byte, rx_byte;
   logic [2:0] bit_cnt;
   logic [1:0] pointer;
   logic       rw_bit, first_byte;
   logic [7:0] shadow_paddle;
   logic [3:0] shadow_buttons;
   logic       start_cond, stop_cond;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk     (clk),
      .reset   (reset),
      .line_in (scl_in),
      .level   (scl_f),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk     (clk),
      .reset   (reset),
      .line_in (sda_in),
      .level   (sda_f),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   assign start_cond = sda_fall & scl_f;
   assign stop_cond  = sda_rise & scl_f;
   assign rx_byte    = {shreg[6:0], sda_f};

   always_comb begin
      rd_byte = 8'h00;
      unique case (pointer)
         REG_PADDLE:  rd_byte = shadow_paddle;
         REG_BUTTONS: rd_byte = {4'b0000, shadow_buttons};
         REG_ID:      rd_byte = ID_VALUE;
         REG_SCRATCH: rd_byte = scratch;
         default:     rd_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= StIdle;
         sda_oe         <= 1'b0;
         scratch        <= 8'h00;
         wr_strobe      <= 1'b0;
         busy           <= 1'b0;
         pointer        <= 2'd0;
         shreg          <= 8'h00;
         tx_byte        <= 8'h00;
         bit_cnt        <= 3'd0;
         rw_bit         <= 1'b0;
         first_byte     <= 1'b0;
         shadow_paddle  <= 8'h00;
         shadow_buttons <= 4'h0;
      end else begin
         wr_strobe <= 1'b0;
         if (start_cond) begin
            state   <= StAddr;
            bit_cnt <= 3'd0;
            sda_oe  <= 1'b0;
         end else if (stop_cond) begin
            state  <= StIdle;
            busy   <= 1'b0;
            sda_oe <= 1'b0;
         end else begin
            case (state)
               StIdle: ;
               StAddr: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (rx_byte[7:1] == ADDR) begin
                        state          <= StAddrAck;
                        busy           <= 1'b1;
                        rw_bit         <= rx_byte[0];
                        first_byte     <= 1'b1;
                        shadow_paddle  <= paddle_y;
                        shadow_buttons <= buttons;
                     end else begin
                        state <= StIdle;
                     end
                  end
               end
               StAddrAck: if (scl_fall) begin
                  sda_oe <= 1'b1;
               end else if (scl_rise) begin
                  bit_cnt <= 3'd0;
                  if (rw_bit) begin
                     state   <= StRdData;
                     tx_byte <= rd_byte;
                  end else begin
                     state <= StWrData;
                  end
               end
               StWrData: if (scl_fall) begin
                  sda_oe <= 1'b0;
               end else if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= StWrAck;
                     if (first_byte) begin
                        pointer    <= rx_byte[1:0];
                        first_byte <= 1'b0;
                     end else begin
                        if (pointer == REG_SCRATCH) scratch <= rx_byte;
                        wr_strobe <= 1'b1;
                        pointer   <= pointer + 2'd1;
                     end
                  end
               end
               StWrAck: if (scl_fall) begin
                  sda_oe <= 1'b1;
               end else if (scl_rise) begin
                  state   <= StWrData;
                  bit_cnt <= 3'd0;
               end
               StRdData: if (scl_fall) begin
                  sda_oe  <= ~tx_byte[7];
                  tx_byte <= {tx_byte[6:0], 1'b0};
               end else if (scl_rise) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     pointer <= pointer + 2'd1;
                     state   <= StRdAck;
                  end
               end
               // busy deliberately survives a NACK; only STOP ends the transaction
               StRdAck: if (scl_fall) begin
                  sda_oe <= 1'b0;
               end else if (scl_rise) begin
                  if (!sda_f) begin
                     state   <= StRdData;
                     tx_byte <= rd_byte;
                     bit_cnt <= 3'd0;
                  end else begin
                     state <= StIdle;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_paddle_target.sv
// Directed bench for i2c_paddle_target: bit-banged I2C controller on an open-drain SDA.
module tb_i2c_paddle_target;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] paddle_y = 8'h00;
   logic [3:0] buttons = 4'h0;
   logic [7:0] scratch;
   logic       wr_strobe;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   int strobe_cnt = 0;
   int oe_cnt = 0;

   assign sda_line = sda_m & ~sda_oe;

   i2c_paddle_target #(
      .ADDR       (7'h52),
      .FILTER_LEN (3),
      .ID_VALUE   (8'hA5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl_m),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .paddle_y  (paddle_y),
      .buttons   (buttons),
      .scratch   (scratch),
      .wr_strobe (wr_strobe),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wr_strobe === 1'b1) strobe_cnt++;
      if (sda_oe === 1'b1) oe_cnt++;
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_bit(input logic b, output logic s);
      sda_m = b;
      wait_clk(10);
      scl_m = 1'b1;
      wait_clk(10);
      s = sda_line;
      scl_m = 1'b0;
      wait_clk(10);
   endtask

   task automatic i2c_start();
      if (scl_m == 1'b0) begin
         sda_m = 1'b1;
         wait_clk(10);
         scl_m = 1'b1;
         wait_clk(10);
      end
      sda_m = 1'b0;
      wait_clk(10);
      scl_m = 1'b0;
      wait_clk(10);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wait_clk(10);
      scl_m = 1'b1;
      wait_clk(10);
      sda_m = 1'b1;
      wait_clk(10);
   endtask

   task automatic i2c_write(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
      i2c_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic i2c_read(input logic ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         i2c_bit(1'b1, s);
         d[i] = s;
      end
      i2c_bit(~ack, s);
   endtask

   task automatic test_reset();
      wait_clk(3);
      n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (scratch !== 8'h00) begin n_err++; $display("FAIL reset_scratch: got %h want 00", scratch); end
      n_cmp++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
      reset = 1'b1;
      wait_clk(10);
   endtask

   task automatic test_write();
      logic a0, a1, a2;
      logic [7:0] d;
      int s0;
      s0 = strobe_cnt;
      i2c_start();
      i2c_write(8'hA4, a0);
      i2c_write(8'h03, a1);
      i2c_write(8'h5C, a2);
      n_cmp++; if (a0 !== 1'b1) begin n_err++; $display("FAIL wr_ack_addr: got %b want 1", a0); end
      n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL wr_ack_ptr: got %b want 1", a1); end
      n_cmp++; if (a2 !== 1'b1) begin n_err++; $display("FAIL wr_ack_data: got %b want 1", a2); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_mid: got %b want 1", busy); end
      i2c_stop();
      wait_clk(10);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
      n_cmp++; if (scratch !== 8'h5C) begin n_err++; $display("FAIL wr_scratch: got %h want 5c", scratch); end
      n_cmp++; if (strobe_cnt - s0 !== 1) begin n_err++; $display("FAIL wr_strobe_count: got %0d want 1", strobe_cnt - s0); end
      // pointer wrapped 3->0, so a bare read returns paddle_y
      paddle_y = 8'h3C;
      i2c_start();
      i2c_write(8'hA5, a0);
      i2c_read(1'b0, d);
      i2c_stop();
      n_cmp++; if (d !== 8'h3C) begin n_err++; $display("FAIL wr_ptr_wrap: got %h want 3c", d); end
   endtask

   task automatic test_read_burst();
      logic a;
      logic [7:0] d0, d1, d2;
      paddle_y = 8'h7E;
      buttons  = 4'b1010;
      i2c_start();
      i2c_write(8'hA4, a);
      i2c_write(8'h00, a);
      i2c_start();
      i2c_write(8'hA5, a);
      n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL rd_ack_addr: got %b want 1", a); end
      i2c_read(1'b1, d0);
      paddle_y = 8'h11;
      buttons  = 4'b0101;
      i2c_read(1'b1, d1);
      i2c_read(1'b0, d2);
      n_cmp++; if (d0 !== 8'h7E) begin n_err++; $display("FAIL rd_byte0: got %h want 7e", d0); end
      n_cmp++; if (d1 !== 8'h0A) begin n_err++; $display("FAIL rd_byte1: got %h want 0a", d1); end
      n_cmp++; if (d2 !== 8'hA5) begin n_err++; $display("FAIL rd_byte2: got %h want a5", d2); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_after_nack: got %b want 1", busy); end
      i2c_stop();
      wait_clk(10);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
   endtask

   task automatic test_addr_mismatch();
      logic a0, a1;
      int s0, o0;
      s0 = strobe_cnt;
      o0 = oe_cnt;
      i2c_start();
      i2c_write(8'hA6, a0);
      i2c_write(8'h5A, a1);
      n_cmp++; if (a0 !== 1'b0) begin n_err++; $display("FAIL mm_addr_ack: got %b want 0", a0); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mm_busy: got %b want 0", busy); end
      i2c_stop();
      n_cmp++; if (oe_cnt - o0 !== 0) begin n_err++; $display("FAIL mm_sda_oe: got %0d want 0", oe_cnt - o0); end
      n_cmp++; if (strobe_cnt - s0 !== 0) begin n_err++; $display("FAIL mm_strobe: got %0d want 0", strobe_cnt - s0); end
   endtask

   task automatic test_glitch();
      logic a, s;
      logic [7:0] d;
      logic [6:0] rest;
      i2c_start();
      sda_m = 1'b1;
      wait_clk(10);
      for (int i = 0; i < 3; i++) begin
         scl_m = 1'b1;
         wait_clk(1);
         scl_m = 1'b0;
         wait_clk(6);
      end
      n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL gl_sda_oe: got %b want 0", sda_oe); end
      i2c_write(8'hA5, a);
      n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL gl_addr_ack: got %b want 1", a); end
      i2c_read(1'b0, d);
      i2c_stop();
      n_cmp++; if (d !== 8'h5C) begin n_err++; $display("FAIL gl_read_scratch: got %h want 5c", d); end
      // first address bit carried by a 3-clk SCL pulse
      paddle_y = 8'h66;
      i2c_start();
      sda_m = 1'b1;
      wait_clk(10);
      scl_m = 1'b1;
      wait_clk(3);
      scl_m = 1'b0;
      wait_clk(10);
      rest = 7'b0100101;
      for (int i = 6; i >= 0; i--) i2c_bit(rest[i], s);
      i2c_bit(1'b1, s);
      n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL gl_short_pulse_ack: got %b want 0", s); end
      i2c_read(1'b0, d);
      i2c_stop();
      n_cmp++; if (d !== 8'h66) begin n_err++; $display("FAIL gl_short_pulse_data: got %h want 66", d); end
   endtask

   task automatic test_stop_mid_addr();
      logic a, s;
      logic [7:0] d;
      i2c_start();
      i2c_write(8'hA4, a);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sm_busy_before: got %b want 1", busy); end
      i2c_start();
      i2c_bit(1'b1, s);
      i2c_bit(1'b0, s);
      i2c_bit(1'b1, s);
      i2c_bit(1'b0, s);
      i2c_stop();
      wait_clk(10);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sm_busy_after: got %b want 0", busy); end
      i2c_start();
      i2c_write(8'hA4, a);
      i2c_write(8'h02, a);
      i2c_start();
      i2c_write(8'hA5, a);
      i2c_read(1'b0, d);
      i2c_stop();
      n_cmp++; if (d !== 8'hA5) begin n_err++; $display("FAIL sm_read_id: got %h want a5", d); end
   endtask

   task automatic test_reset_mid_read();
      logic a;
      logic [7:0] d;
      paddle_y = 8'h3C;
      buttons  = 4'h0;
      i2c_start();
      i2c_write(8'hA4, a);
      i2c_write(8'h01, a);
      i2c_start();
      i2c_write(8'hA5, a);
      // first data bit of 0x00 holds SDA low
      n_cmp++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rr_oe_before: got %b want 1", sda_oe); end
      reset = 1'b0;
      #1;
      n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rr_oe_async: got %b want 0", sda_oe); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_busy: got %b want 0", busy); end
      n_cmp++; if (scratch !== 8'h00) begin n_err++; $display("FAIL rr_scratch: got %h want 00", scratch); end
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_clk(10);
      reset = 1'b1;
      wait_clk(10);
      i2c_start();
      i2c_write(8'hA5, a);
      i2c_read(1'b0, d);
      i2c_stop();
      n_cmp++; if (d !== 8'h3C) begin n_err++; $display("FAIL rr_ptr_zero: got %h want 3c", d); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_burst();
      test_addr_mismatch();
      test_glitch();
      test_stop_mid_addr();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
